// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and helpers for the arbitrating multiplexer.
//   ARB_RR     - round-robin arbitration mode
//   ARB_FIXED  - fixed-priority arbitration mode (lowest index wins)
//   sel_width  - channel index width, at least one bit even for N=1
package arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_n_grant.sv
// arb_grant: purely combinational request arbiter.
// Scans req starting at base (round-robin) or at 0 (fixed priority) and
// picks the first requesting channel, wrapping modulo N.
// Ports:
//   req     in   N      per-channel requests
//   base    in   SEL_W  first channel examined in round-robin mode
//   mode    in   1      0 = round-robin from base, 1 = fixed priority from 0
//   grant   out  N      one-hot grant (all zero when nothing requests)
//   idx     out  SEL_W  encoded index of the granted channel
//   any_req out  1      at least one request is present
module arb_grant
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] base,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any_req
);

    int start;
    int k;

    // any_req doubles as the "already found" flag so only the first hit in
    // scan order is granted.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        k       = 0;
        start   = mode ? 0 : int'(base);
        for (int i = 0; i < N; i++) begin
            k = start + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any_req && req[k]) begin
                any_req  = 1'b1;
                grant[k] = 1'b1;
                idx      = k[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrating multiplexer with a registered output
// stage and valid/ready handshakes on every port.
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        synchronous reset, active-high
//   in_valid  in   N        per-channel request valid
//   in_data   in   N*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   in_ready  out  N        per-channel accept, at most one bit high
//   out_valid out  1        output register holds a word
//   out_data  out  WIDTH    registered selected word
//   out_ch    out  SEL_W    channel that produced out_data
//   out_ready in   1        downstream accept
module arb_mux_n
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int MODE  = ARB_RR,
    parameter int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     gnt_onehot;
    logic [SEL_W-1:0] gnt_idx;
    logic             any_req;
    logic             load;

    arb_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_grant (
        .req     (in_valid),
        .base    (ptr),
        .mode    (MODE == ARB_FIXED),
        .grant   (gnt_onehot),
        .idx     (gnt_idx),
        .any_req (any_req)
    );

    // The output register can take a new word whenever it is empty or is
    // being drained this same cycle, which is what gives bubble-free streaming.
    assign load     = !out_valid || out_ready;
    assign in_ready = (!rst && load && any_req) ? gnt_onehot : '0;

    // The pointer moves to the channel after the winner only on a real
    // transfer, so idle and stalled cycles do not disturb fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_ch    <= gnt_idx;
                if (MODE == ARB_RR) begin
                    ptr <= (gnt_idx == SEL_W'(N-1)) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed, table-driven bench for arb_mux_n.
// Four instances: N=8 round-robin (table), N=8 fixed priority,
// N=5 round-robin (non-power-of-two wrap) and N=1.
module tb_arb_mux_n;

    logic clk;

    // N=8 round-robin instance
    logic         rst0;
    logic [7:0]   in_valid0;
    logic [255:0] in_data0;
    logic [7:0]   in_ready0;
    logic         out_valid0;
    logic [31:0]  out_data0;
    logic [2:0]   out_ch0;
    logic         out_ready0;

    // N=8 fixed priority instance
    logic         rst1;
    logic [7:0]   in_valid1;
    logic [255:0] in_data1;
    logic [7:0]   in_ready1;
    logic         out_valid1;
    logic [31:0]  out_data1;
    logic [2:0]   out_ch1;
    logic         out_ready1;

    // N=5 round-robin instance
    logic         rst2;
    logic [4:0]   in_valid2;
    logic [159:0] in_data2;
    logic [4:0]   in_ready2;
    logic         out_valid2;
    logic [31:0]  out_data2;
    logic [2:0]   out_ch2;
    logic         out_ready2;

    // N=1 instance
    logic         rst3;
    logic [0:0]   in_valid3;
    logic [7:0]   in_data3;
    logic [0:0]   in_ready3;
    logic         out_valid3;
    logic [7:0]   out_data3;
    logic [0:0]   out_ch3;
    logic         out_ready3;

    int total_count;
    int bad_count;

    typedef struct {
        logic        rst;
        logic [7:0]  valid;
        logic        ready;
        logic [7:0]  exp_ready;
        logic        exp_ov;
        logic [2:0]  exp_ch;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    arb_mux_n #(.WIDTH(32), .N(8), .MODE(0)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ch(out_ch0), .out_ready(out_ready0)
    );

    arb_mux_n #(.WIDTH(32), .N(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ch(out_ch1), .out_ready(out_ready1)
    );

    arb_mux_n #(.WIDTH(32), .N(5), .MODE(0)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ch(out_ch2), .out_ready(out_ready2)
    );

    arb_mux_n #(.WIDTH(8), .N(1), .MODE(0)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ch(out_ch3), .out_ready(out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int vec_idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s vec=%0d actual=%h expected=%h", name, vec_idx, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic [7:0] v, input logic rdy,
                          input logic [7:0] er, input logic eov, input logic [2:0] ech,
                          input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.ready = rdy;
        t.exp_ready = er; t.exp_ov = eov; t.exp_ch = ech; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst0       = v.rst;
        in_valid0  = v.valid;
        out_ready0 = v.ready;
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        in_valid0 = '0; in_valid1 = '0; in_valid2 = '0; in_valid3 = '0;
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data0[k*32 +: 32] = 32'hA0 + k;
            in_data1[k*32 +: 32] = 32'hA0 + k;
        end
        for (int k = 0; k < 5; k++) begin
            in_data2[k*32 +: 32] = 32'hB0 + k;
        end
        in_data3 = 8'h5C;

        // rst, valid, out_ready, exp in_ready, exp out_valid, exp out_ch, exp out_data
        addVec(1, 8'hFF, 1, 8'h00, 0, 0, 32'h0);
        addVec(1, 8'hFF, 1, 8'h00, 0, 0, 32'h0);
        for (int j = 0; j < 10; j++) begin
            addVec(0, 8'hFF, 1, 8'(1 << (j % 8)), 1, 3'(j % 8), 32'hA0 + 32'(j % 8));
        end
        addVec(0, 8'hFF, 0, 8'h00, 1, 1, 32'hA1);
        addVec(0, 8'hFF, 0, 8'h00, 1, 1, 32'hA1);
        addVec(0, 8'hFF, 0, 8'h00, 1, 1, 32'hA1);
        addVec(0, 8'hFF, 1, 8'h04, 1, 2, 32'hA2);
        addVec(0, 8'h00, 1, 8'h00, 0, 2, 32'hA2);
        addVec(0, 8'h00, 1, 8'h00, 0, 2, 32'hA2);
        addVec(0, 8'h18, 1, 8'h08, 1, 3, 32'hA3);
        addVec(0, 8'h18, 1, 8'h10, 1, 4, 32'hA4);
        addVec(0, 8'h18, 1, 8'h08, 1, 3, 32'hA3);
        addVec(0, 8'h04, 1, 8'h04, 1, 2, 32'hA2);
        addVec(1, 8'hFF, 0, 8'h00, 0, 0, 32'h0);
        addVec(0, 8'h0A, 1, 8'h02, 1, 1, 32'hA1);
        addVec(0, 8'h0A, 1, 8'h08, 1, 3, 32'hA3);
        addVec(0, 8'h00, 1, 8'h00, 0, 3, 32'hA3);
        addVec(0, 8'h01, 0, 8'h01, 1, 0, 32'hA0);
        addVec(0, 8'h01, 0, 8'h00, 1, 0, 32'hA0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput("rr8_in_ready", i, 32'(in_ready0), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            checkOutput("rr8_out_valid", i, 32'(out_valid0), 32'(vecs[i].exp_ov));
            checkOutput("rr8_out_ch", i, 32'(out_ch0), 32'(vecs[i].exp_ch));
            checkOutput("rr8_out_data", i, out_data0, vecs[i].exp_data);
        end

        // Fixed priority: ch2 always beats ch5 and ch7.
        rst1 = 1'b0;
        in_valid1 = 8'b1010_0100;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("fix_in_ready", i, 32'(in_ready1), 32'h04);
            @(posedge clk);
            #1;
            checkOutput("fix_out_valid", i, 32'(out_valid1), 32'h1);
            checkOutput("fix_out_ch", i, 32'(out_ch1), 32'h2);
            checkOutput("fix_out_data", i, out_data1, 32'hA2);
        end
        in_valid1 = 8'b1010_0000;
        #1;
        checkOutput("fix_in_ready_ch5", 6, 32'(in_ready1), 32'h20);
        @(posedge clk);
        #1;
        checkOutput("fix_out_ch_ch5", 6, 32'(out_ch1), 32'h5);

        // N=5 round-robin with ch0 and ch4 requesting: wraps at index 4.
        rst2 = 1'b0;
        in_valid2 = 5'b10001;
        for (int i = 0; i < 6; i++) begin
            int ech;
            ech = (i % 2 == 0) ? 0 : 4;
            #1;
            checkOutput("rr5_in_ready", i, 32'(in_ready2), 32'(1 << ech));
            @(posedge clk);
            #1;
            checkOutput("rr5_out_valid", i, 32'(out_valid2), 32'h1);
            checkOutput("rr5_out_ch", i, 32'(out_ch2), 32'(ech));
            checkOutput("rr5_out_data", i, out_data2, 32'hB0 + 32'(ech));
        end

        // N=1: single channel always granted.
        rst3 = 1'b0;
        in_valid3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("n1_in_ready", i, 32'(in_ready3), 32'h1);
            @(posedge clk);
            #1;
            checkOutput("n1_out_valid", i, 32'(out_valid3), 32'h1);
            checkOutput("n1_out_ch", i, 32'(out_ch3), 32'h0);
            checkOutput("n1_out_data", i, 32'(out_data3), 32'h5C);
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
